// File: rtl/accum_drain_pkg.sv
// -----------------------------------------------------------------------------
// accum_drain_pkg
// Shared sizing for the accum_buf drain path and the drain FSM state encoding.
//   DEPTH_DEF / BATCH_DEF : default row count and lanes per row of accum_buf
//   ADDR_W                : accum_buf row address width
//   RES_W                 : width of one accumulated result lane
//   drain_state_t         : IDLE / RUN / FLUSH
// -----------------------------------------------------------------------------
package accum_drain_pkg;

    localparam int DEPTH_DEF = 256;
    localparam int BATCH_DEF = 32;
    localparam int ADDR_W    = 8;
    localparam int RES_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

endpackage

// File: rtl/accum_drain_if.sv
// -----------------------------------------------------------------------------
// accum_drain_if
// Valid/ready result-row stream from the drain toward the output/DDR writer.
//   out_valid : row available
//   out_ready : consumer accepts the row
//   out_data  : BATCH result lanes, lane i at [i*RES_W +: RES_W]
//   out_last  : final row of the current drain
// master = producer (accum_drain), slave = consumer.
// -----------------------------------------------------------------------------
interface accum_drain_if
    import accum_drain_pkg::*;
#(
    parameter int DATA_W = BATCH_DEF * RES_W
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/accum_drain_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO used to absorb the accum_buf read latency.
//   clk, rst  : clock, synchronous active-high reset (pointers/count only)
//   push      : write push_data this cycle (caller guarantees not full)
//   push_data : entry to store
//   pop       : drop the head entry this cycle (caller guarantees not empty)
//   count     : number of stored entries
//   head      : oldest entry; held stable until popped
// Push and pop in the same cycle leave count unchanged.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage carries data only, no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/accum_drain.sv
// -----------------------------------------------------------------------------
// accum_drain
// Walks a range of accum_buf rows through the store read port and streams
// each BATCH-wide row out on a valid/ready interface.
//   clk, rst   : clock, synchronous active-high reset
//   start      : 1-cycle pulse, begins a drain (ignored while busy)
//   base_addr  : first row to read, sampled with start
//   len        : rows to read, 0..DEPTH (larger values saturate to DEPTH)
//   busy       : drain in progress
//   done       : 1-cycle pulse after the final row handshake
//   sv_rd_addr : accum_buf read address (held when no read is issued)
//   sv_rd_data : row for the address registered on the previous cycle
//   out_if     : result row stream (master side)
// -----------------------------------------------------------------------------
module accum_drain
    import accum_drain_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int BATCH  = BATCH_DEF,
    parameter int FIFO_D = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          len,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        sv_rd_addr,
    input  logic [BATCH*RES_W-1:0]   sv_rd_data,
    accum_drain_if.master            out_if
);
    localparam int DW    = BATCH * RES_W;
    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int OCC_W = CNT_W + 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_FLUSH = FLUSH;

    logic [1:0]       state;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] cap_cnt;
    logic [ADDR_W-1:0] addr_ptr;
    logic             inflight;

    logic [LEN_W-1:0] len_sat;
    logic [OCC_W-1:0] occ;
    logic             issue;
    logic             pop;
    logic             push_last;
    logic [CNT_W-1:0] fifo_cnt;
    logic [DW:0]      fifo_head;
    logic             head_last;

    assign len_sat = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;

    assign pop = out_if.out_valid & out_if.out_ready;

    // Occupancy the FIFO will have after this cycle's pop, counting the read
    // already on its way back. Issuing only below FIFO_D means a captured
    // row always has a slot, so stalls never drop or duplicate rows.
    assign occ   = OCC_W'(fifo_cnt) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue = (state == S_RUN) && (issued < len_r) && (occ < OCC_W'(FIFO_D));

    assign push_last = (cap_cnt == len_r - LEN_W'(1));

    // ---- stage p0: read issue / FSM ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len_r      <= '0;
            issued     <= '0;
            cap_cnt    <= '0;
            addr_ptr   <= '0;
            sv_rd_addr <= '0;
            inflight   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;

            if (issue) begin
                sv_rd_addr <= addr_ptr;
                addr_ptr   <= (addr_ptr == ADDR_W'(DEPTH - 1)) ? '0
                                                               : addr_ptr + ADDR_W'(1);
                issued     <= issued + LEN_W'(1);
            end

            if (inflight) cap_cnt <= cap_cnt + LEN_W'(1);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_r    <= len_sat;
                        addr_ptr <= base_addr;
                        issued   <= '0;
                        cap_cnt  <= '0;
                        if (len_sat == '0) done  <= 1'b1;
                        else               state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue && (issued == len_r - LEN_W'(1))) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    // the tagged row leaving the FIFO empties the drain
                    if (pop && head_last) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    // ---- stage p1: capture of the returned row into the FIFO ----
    sync_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({push_last, sv_rd_data}),
        .pop       (pop),
        .count     (fifo_cnt),
        .head      (fifo_head)
    );

    assign head_last        = fifo_head[DW];
    assign out_if.out_valid = (fifo_cnt != '0);
    assign out_if.out_data  = fifo_head[DW-1:0];
    // storage is not reset, so qualify the tag to keep out_last low when empty
    assign out_if.out_last  = out_if.out_valid & head_last;

endmodule

// File: tb/tb_accum_drain.sv
module tb_accum_drain;
    import accum_drain_pkg::*;

    localparam int DEPTH  = 256;
    localparam int BATCH  = 32;
    localparam int FIFO_D = 2;
    localparam int DW     = BATCH * RES_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sv_rd_addr;
    logic [DW-1:0]     sv_rd_data;

    accum_drain_if #(.DATA_W(DW)) out_if ();

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    accum_drain #(
        .DEPTH  (DEPTH),
        .BATCH  (BATCH),
        .FIFO_D (FIFO_D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .sv_rd_addr (sv_rd_addr),
        .sv_rd_data (sv_rd_data),
        .out_if     (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // accum_buf model: data for the address registered on the previous edge
    assign sv_rd_data = mem[sv_rd_addr];

    // row r, lane i holds r*32+i
    function automatic logic [DW-1:0] row_val(input int r);
        logic [DW-1:0] v;
        for (int i = 0; i < BATCH; i++) v[i*RES_W +: RES_W] = RES_W'(r * 32 + i);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller one cycle after the start edge (start already low).
    task automatic start_drain(input int b, input int l);
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        len       = (ADDR_W+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        out_if.out_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_if.out_valid); end
        n_checks++; if (out_if.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", out_if.out_last); end
        n_checks++; if (sv_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", sv_rd_addr); end
        n_checks++; if (dut.fifo_cnt !== '0) begin n_fail++; $display("FAIL reset_fifo_cnt got %0d want 0", dut.fifo_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic exp_v;
        out_if.out_ready = 1'b1;
        start_drain(0, 8);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
        for (int k = 1; k <= 12; k++) begin
            exp_v = (k >= 3 && k <= 10);
            n_checks++;
            if (out_if.out_valid !== exp_v) begin n_fail++; $display("FAIL basic_valid cyc %0d got %b want %b", k, out_if.out_valid, exp_v); end
            if (exp_v) begin
                n_checks++;
                if (out_if.out_data !== row_val(k - 3)) begin n_fail++; $display("FAIL basic_data cyc %0d got %h want %h", k, out_if.out_data[31:0], row_val(k - 3)); end
                n_checks++;
                if (out_if.out_last !== (k == 10)) begin n_fail++; $display("FAIL basic_last cyc %0d got %b want %b", k, out_if.out_last, (k == 10)); end
            end
            n_checks++;
            if (done !== (k == 11)) begin n_fail++; $display("FAIL basic_done cyc %0d got %b want %b", k, done, (k == 11)); end
            if (k == 11) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        int exp_a [4];
        exp_a = '{254, 255, 0, 1};
        out_if.out_ready = 1'b1;
        start_drain(254, 4);
        for (int k = 1; k <= 8; k++) begin
            if (k >= 2 && k <= 5) begin
                n_checks++;
                if (sv_rd_addr !== ADDR_W'(exp_a[k-2])) begin n_fail++; $display("FAIL wrap_addr cyc %0d got %0d want %0d", k, sv_rd_addr, exp_a[k-2]); end
            end
            if (k >= 3 && k <= 6) begin
                n_checks++;
                if (out_if.out_valid !== 1'b1 || out_if.out_data !== row_val(exp_a[k-3])) begin
                    n_fail++; $display("FAIL wrap_data cyc %0d got v=%b %h want row %0d", k, out_if.out_valid, out_if.out_data[31:0], exp_a[k-3]);
                end
            end
            n_checks++;
            if (done !== (k == 7)) begin n_fail++; $display("FAIL wrap_done cyc %0d got %b want %b", k, done, (k == 7)); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        int dones = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        start_drain(10, 16);
        for (int k = 1; k <= 200 && dones == 0; k++) begin
            out_if.out_ready = (k % 4 == 0) || (k % 4 == 3);
            if (stalled) begin
                n_checks++;
                if (out_if.out_valid !== 1'b1 || out_if.out_data !== prev_d || out_if.out_last !== prev_l) begin
                    n_fail++; $display("FAIL bp_stable cyc %0d got v=%b %h want held %h", k, out_if.out_valid, out_if.out_data[31:0], prev_d[31:0]);
                end
            end
            stalled = out_if.out_valid && !out_if.out_ready;
            prev_d  = out_if.out_data;
            prev_l  = out_if.out_last;
            if (out_if.out_valid && out_if.out_ready) begin
                n_checks++;
                if (out_if.out_data !== row_val(10 + beats)) begin n_fail++; $display("FAIL bp_data beat %0d got %h want row %0d", beats, out_if.out_data[31:0], 10 + beats); end
                n_checks++;
                if (out_if.out_last !== (beats == 15)) begin n_fail++; $display("FAIL bp_last beat %0d got %b want %b", beats, out_if.out_last, (beats == 15)); end
                beats++;
            end
            n_checks++;
            if (int'(dut.fifo_cnt) > FIFO_D) begin n_fail++; $display("FAIL bp_fifo_cnt cyc %0d got %0d want <= %0d", k, dut.fifo_cnt, FIFO_D); end
            if (done) dones++;
            tick();
        end
        out_if.out_ready = 1'b1;
        n_checks++; if (beats != 16) begin n_fail++; $display("FAIL bp_beats got %0d want 16", beats); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL bp_dones got %0d want 1", dones); end
        repeat (2) tick();
    endtask

    task automatic test_len_zero_and_busy_start();
        logic [ADDR_W-1:0] a0;
        int beats = 0;
        int dones = 0;
        int last_idx = -1;
        out_if.out_ready = 1'b1;
        a0 = sv_rd_addr;
        start_drain(5, 0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done got %b want 1", done); end
        n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL len0_valid got %b want 0", out_if.out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy got %b want 0", busy); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL len0_done2 got %b want 0", done); end
        n_checks++; if (out_if.out_valid !== 1'b0 || sv_rd_addr !== a0) begin
            n_fail++; $display("FAIL len0_quiet got v=%b addr=%0d want v=0 addr=%0d", out_if.out_valid, sv_rd_addr, a0);
        end
        // a second start while busy must be ignored
        start_drain(0, 4);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_busy got %b want 1", busy); end
        start_drain(100, 8);
        for (int k = 2; k <= 20; k++) begin
            if (out_if.out_valid) begin
                n_checks++;
                if (out_if.out_data !== row_val(beats)) begin n_fail++; $display("FAIL busy_start_data beat %0d got %h want row %0d", beats, out_if.out_data[31:0], beats); end
                if (out_if.out_last) last_idx = beats;
                beats++;
            end
            if (done) dones++;
            tick();
        end
        n_checks++; if (beats != 4) begin n_fail++; $display("FAIL busy_start_beats got %0d want 4", beats); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL busy_start_dones got %0d want 1", dones); end
        n_checks++; if (last_idx != 3) begin n_fail++; $display("FAIL busy_start_last got %0d want 3", last_idx); end
    endtask

    task automatic test_len_saturate();
        int beats = 0;
        int lasts = 0;
        int last_idx = -1;
        int done_cyc = -1;
        int bad = 0;
        out_if.out_ready = 1'b1;
        start_drain(0, DEPTH + 5);
        for (int k = 1; k <= 300; k++) begin
            if (out_if.out_valid) begin
                if (out_if.out_data !== row_val(beats % DEPTH)) bad++;
                if (out_if.out_last) begin lasts++; last_idx = beats; end
                beats++;
            end
            if (done && done_cyc < 0) done_cyc = k;
            tick();
        end
        n_checks++; if (beats != DEPTH) begin n_fail++; $display("FAIL sat_beats got %0d want %0d", beats, DEPTH); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sat_data got %0d bad rows want 0", bad); end
        n_checks++; if (lasts != 1 || last_idx != DEPTH - 1) begin
            n_fail++; $display("FAIL sat_last got count %0d at beat %0d want 1 at %0d", lasts, last_idx, DEPTH - 1);
        end
        n_checks++; if (done_cyc != DEPTH + 3) begin n_fail++; $display("FAIL sat_done_cyc got %0d want %0d", done_cyc, DEPTH + 3); end
    endtask

    task automatic test_mid_reset();
        int stray = 0;
        out_if.out_ready = 1'b1;
        start_drain(0, 8);
        tick();                       // cycle 2
        tick();                       // cycle 3: beat 0
        tick();                       // cycle 4: beat 1
        tick();                       // cycle 5: beat 2
        n_checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== row_val(2)) begin
            n_fail++; $display("FAIL rst_pre_beat got v=%b %h want row 2", out_if.out_valid, out_if.out_data[31:0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_if.out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        for (int k = 0; k < 8; k++) begin
            if (out_if.out_valid || done) stray++;
            tick();
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL rst_stray got %0d want 0", stray); end
        start_drain(40, 3);
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (out_if.out_valid !== (k >= 3 && k <= 5)) begin n_fail++; $display("FAIL rst_re_valid cyc %0d got %b", k, out_if.out_valid); end
            if (k >= 3 && k <= 5) begin
                n_checks++;
                if (out_if.out_data !== row_val(40 + k - 3) || out_if.out_last !== (k == 5)) begin
                    n_fail++; $display("FAIL rst_re_data cyc %0d got %h last=%b want row %0d", k, out_if.out_data[31:0], out_if.out_last, 40 + k - 3);
                end
            end
            n_checks++;
            if (done !== (k == 6)) begin n_fail++; $display("FAIL rst_re_done cyc %0d got %b want %b", k, done, (k == 6)); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < DEPTH; r++) mem[r] = row_val(r);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero_and_busy_start();
        test_len_saturate();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
